ir_cmd_sequencer: RTL and testbench

- Sits between the IR frame receiver and the LED manager / command display.
- Turns the receiver's level-style `data`/`data_rdy` outputs into a filtered, de-duplicated, buffered command stream with a valid/ready handshake.
- Drops frames addressed to other devices.
- Suppresses auto-repeated frames while a remote key is held.
- Queues bursts so no command is lost while the consumer is busy.

---
 rtl/ir_cmd_if.sv | 26 ++
 rtl/ir_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ir_cmd_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ir_cmd_if.sv
// Command-stream bundle between the IR receiver, ir_cmd_sequencer and its consumer.
// master: the sequencer; slave: receiver/consumer side (or a testbench).
interface ir_cmd_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [11:0]   rx_data;
    logic          rx_rdy;
    logic [11:0]   cmd_out;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          held;

    modport master (
        input  rx_data, rx_rdy, cmd_ready,
        output cmd_out, cmd_valid, fifo_count, overflow, held
    );

    modport slave (
        output rx_data, rx_rdy, cmd_ready,
        input  cmd_out, cmd_valid, fifo_count, overflow, held
    );
endinterface

// File: rtl/ir_cmd_sequencer.sv
// IR frame edge-detect, address filter, held-key de-duplication and FWFT command FIFO.
// Optional macro IR_CMD_AUTOREPEAT_EN: re-emit a held key from its 5th identical frame on.
module ir_cmd_sequencer #(
    parameter int         DEPTH      = 4,
    parameter int         REPEAT_GAP = 3000000,
    parameter logic [4:0] ADDR       = 5'd1
) (
    input logic      clk,
    input logic      rst,
    ir_cmd_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(REPEAT_GAP);
    localparam logic [TW-1:0] RELOAD = TW'(REPEAT_GAP - 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    typedef struct packed {
        logic [4:0] addr;
        logic [6:0] cmd;
    } ir_frame_t;

    typedef enum logic {IDLE, HELD} state_t;

    state_t        state, state_nx;
    ir_frame_t     rx_f, last;
    logic          rx_rdy_q;
    logic          frame, accept, same;
    logic [TW-1:0] timer;
    logic          push_req, load, last_we;

    logic [11:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nx;
    logic [CW-1:0] count, count_nx;
    logic [11:0]   cmd_q, head_nx;
    logic          full, pop, push_ok;
    logic          overflow_q, held_q;

`ifdef IR_CMD_AUTOREPEAT_EN
    logic [1:0]    rep_cnt;
    logic          rep_clr, rep_inc;
`endif

    assign rx_f   = bus.rx_data;
    assign frame  = bus.rx_rdy & ~rx_rdy_q;
    assign accept = frame & (rx_f.addr == ADDR);
    assign same   = (rx_f == last);

    // History resets high so a level already asserted at release is not a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_rdy_q <= 1'b1;
        else     rx_rdy_q <= bus.rx_rdy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = HELD;
            HELD:    if (!accept && timer == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        load     = 1'b0;
        last_we  = 1'b0;
`ifdef IR_CMD_AUTOREPEAT_EN
        rep_clr  = 1'b0;
        rep_inc  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    push_req = 1'b1;
                    load     = 1'b1;
                    last_we  = 1'b1;
`ifdef IR_CMD_AUTOREPEAT_EN
                    rep_clr  = 1'b1;
`endif
                end
            end
            HELD: begin
                if (accept) begin
                    load = 1'b1;
                    if (same) begin
`ifdef IR_CMD_AUTOREPEAT_EN
                        rep_inc  = 1'b1;
                        push_req = (rep_cnt == 2'd3);
`endif
                    end else begin
                        push_req = 1'b1;
                        last_we  = 1'b1;
`ifdef IR_CMD_AUTOREPEAT_EN
                        rep_clr  = 1'b1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    // Timer parks at 0 once the key is released; every matching frame reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 timer <= '0;
        else if (load)                           timer <= RELOAD;
        else if (state == HELD && timer != '0)   timer <= timer - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last <= '0;
        else if (last_we) last <= rx_f;
    end

`ifdef IR_CMD_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            rep_cnt <= '0;
        else if (rep_clr)                   rep_cnt <= '0;
        else if (rep_inc && rep_cnt != 2'd3) rep_cnt <= rep_cnt + 2'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) held_q <= 1'b0;
        else     held_q <= (state_nx == HELD);
    end

    assign full     = (count == FULL);
    assign pop      = (count != '0) & bus.cmd_ready;
    assign push_ok  = push_req & (~full | pop);
    assign count_nx = count + CW'(push_ok) - CW'(pop);
    assign rd_nx    = rd_ptr + PW'(pop);

    // Registered head: bypass the incoming frame when it lands on the next read slot.
    assign head_nx  = (push_ok && wr_ptr == rd_nx) ? bus.rx_data : mem[rd_nx];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cmd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_nx;
            count  <= count_nx;
            cmd_q  <= head_nx;
            if (push_req && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.cmd_out    = cmd_q;
    assign bus.cmd_valid  = (count != '0);
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow_q;
    assign bus.held       = held_q;
endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// Scoreboard bench for ir_cmd_sequencer: directed plan scenarios then randomized frames.
module tb_ir_cmd_sequencer;
    localparam int         DEPTH = 4;
    localparam int         GAP   = 100;
    localparam logic [4:0] ADDR  = 5'd1;
`ifdef IR_CMD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ir_cmd_if #(.DEPTH(DEPTH)) bus ();

    ir_cmd_sequencer #(.DEPTH(DEPTH), .REPEAT_GAP(GAP), .ADDR(ADDR)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: key-held bookkeeping in cycles, FIFO as occupancy + data queue.
    logic [11:0] sb[$];
    int          m_count = 0;
    bit          m_held  = 0;
    bit          m_ovf   = 0;
    bit          m_prev  = 1;
    logic [11:0] m_last  = '0;
    int          m_same  = 0;
    longint      m_cyc   = 0;
    longint      m_lastcyc = 0;
    bit          rnd_ready = 0;

    task automatic chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit edge_s, pop, push;
        logic [11:0] d;
        if (rst) begin
            m_count = 0; m_held = 0; m_ovf = 0; m_prev = 1;
            m_last = '0; m_same = 0; sb.delete();
        end else begin
            m_cyc++;
            d      = bus.rx_data;
            edge_s = bus.rx_rdy && !m_prev;
            m_prev = bus.rx_rdy;
            pop    = (m_count > 0) && bus.cmd_ready;
            push   = 0;
            if (edge_s && d[11:7] == ADDR) begin
                if (!m_held) begin
                    push = 1; m_held = 1; m_last = d; m_same = 1;
                end else if (d == m_last) begin
                    m_same++;
                    if (AR && m_same >= 5) push = 1;
                end else begin
                    push = 1; m_last = d; m_same = 1;
                end
                m_lastcyc = m_cyc;
            end else if (m_held && (m_cyc - m_lastcyc) >= GAP) begin
                m_held = 0;
            end
            if (push) begin
                if (m_count < DEPTH || pop) begin
                    sb.push_back(d);
                    m_count++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (pop) m_count--;
        end
    end

    // Monitor: mid-cycle, compares status and consumes the head on a handshake.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", bus.cmd_valid, 0);
            chk("rst_out", bus.cmd_out, 0);
            chk("rst_count", bus.fifo_count, 0);
            chk("rst_ovf", bus.overflow, 0);
            chk("rst_held", bus.held, 0);
        end else begin
            chk("fifo_count", bus.fifo_count, m_count);
            chk("cmd_valid", bus.cmd_valid, m_count > 0);
            chk("held", bus.held, m_held);
            chk("overflow", bus.overflow, m_ovf);
            if (bus.cmd_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd", bus.cmd_out, 12'hFFF);
                end else begin
                    chk("cmd_out", bus.cmd_out, sb[0]);
                    if (bus.cmd_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rnd_ready) bus.cmd_ready = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic send(logic [11:0] d, int hi, int lo);
        bus.rx_data = d;
        bus.rx_rdy  = 1'b1;
        tick(hi);
        bus.rx_rdy  = 1'b0;
        tick(lo);
    endtask

    initial begin
        logic [11:0] d;
        bus.rx_data   = '0;
        bus.rx_rdy    = 1'b0;
        bus.cmd_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        send(12'h0A5, 1, 120);
        for (int i = 0; i < 5; i++) send(12'h0A5, 1, 44);
        tick(120);
        send(12'h125, 1, 5);

        bus.cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(12'h080 + 12'(i), 1, 3);
        bus.rx_data   = 12'h086;
        bus.rx_rdy    = 1'b1;
        bus.cmd_ready = 1'b1;
        tick();
        bus.rx_rdy    = 1'b0;
        bus.cmd_ready = 1'b0;
        tick(3);
        bus.cmd_ready = 1'b1;
        tick(10);

        send(12'h0A7, 1, 10);
        bus.rx_rdy = 1'b1;
        tick();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        bus.rx_rdy = 1'b0;
        tick();
        send(12'h0A9, 1, 130);

        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            d[11:7] = ($urandom_range(0, 4) == 0) ? 5'd2 : ADDR;
            d[6:0]  = 7'($urandom_range(0, 3));
            send(d, $urandom_range(1, 3), ($urandom_range(0, 3) == 0) ?
                 $urandom_range(80, 140) : $urandom_range(1, 50));
        end
        rnd_ready = 0;
        bus.cmd_ready = 1'b1;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
